// File: rtl/generic_bus_sram_responder_pkg.sv
// Shared types and fault decode for the generic-bus scratchpad responder.
package generic_bus_sram_responder_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  byte_en_t;

    // A request faults when it is out of range, strobes both directions, or writes no lanes.
    function automatic logic access_fault(input logic in_range, input logic ren,
                                          input logic wen, input byte_en_t byte_en);
        return !in_range || (ren && wen) || (wen && (byte_en == 4'b0000));
    endfunction

endpackage

// File: rtl/generic_bus_sram_responder_if.sv
// Generic memory bus between a pipeline memory stage (master) and a responder (slave).
interface generic_bus_sram_responder_if;
    import generic_bus_sram_responder_pkg::*;

    word_t    addr;
    logic     ren;
    logic     wen;
    word_t    wdata;
    byte_en_t byte_en;
    word_t    rdata;
    logic     busy;
    logic     error;

    modport master (output addr, ren, wen, wdata, byte_en, input rdata, busy, error);
    modport slave  (input addr, ren, wen, wdata, byte_en, output rdata, busy, error);

endinterface

// File: rtl/generic_bus_sram_responder_sram_1rw_be.sv
// Single-port word array with per-byte write enables; combinational read so a BRAM macro can replace it.
module sram_1rw_be
    import generic_bus_sram_responder_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     CLK,
    input  byte_en_t                 we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  word_t                    wdata,
    output word_t                    rdata
);

    word_t mem [DEPTH];

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/generic_bus_sram_responder.sv
// Byte-maskable scratchpad responder with configurable request-to-response latency.
module generic_bus_sram_responder
    import generic_bus_sram_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LAT       = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    generic_bus_sram_responder_if.slave   bus_if
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [32:0] BASE33   = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIMIT33  = BASE33 + 33'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       go_resp;

    word_t      addr_p0, wdata_p0;
    byte_en_t   byte_en_p0;
    logic       ren_p0, wen_p0;

    word_t      rdata_p1;
    logic       busy_p1, error_p1;

    word_t      cur_addr, cur_wdata;
    byte_en_t   cur_be;
    logic       cur_ren, cur_wen;
    logic       req, mismatch, in_range, fault;
    logic [32:0] addr33, off33;
    logic [IDX_W-1:0] index;
    word_t      mem_rdata;
    byte_en_t   mem_we;

    assign req      = bus_if.ren | bus_if.wen;
    assign mismatch = (bus_if.ren != ren_p0) || (bus_if.wen != wen_p0) ||
                      (bus_if.addr != addr_p0) || !req;

    // In IDLE the live request is decoded so LAT=1 can respond on the very next edge.
    always_comb begin
        cur_addr  = addr_p0;
        cur_wdata = wdata_p0;
        cur_be    = byte_en_p0;
        cur_ren   = ren_p0;
        cur_wen   = wen_p0;
        if (state == IDLE) begin
            cur_addr  = bus_if.addr;
            cur_wdata = bus_if.wdata;
            cur_be    = bus_if.byte_en;
            cur_ren   = bus_if.ren;
            cur_wen   = bus_if.wen;
        end
    end

    // 33-bit decode keeps a BASE_ADDR near the top of the map from wrapping.
    assign addr33   = {1'b0, cur_addr};
    assign off33    = addr33 - BASE33;
    assign in_range = (addr33 >= BASE33) && (addr33 < LIMIT33);
    assign index    = IDX_W'(off33 >> 2);
    assign fault    = access_fault(in_range, cur_ren, cur_wen, cur_be);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        go_resp   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nxt = CNT_INIT;
                    if (CNT_INIT == 4'd0) begin
                        state_nxt = RESP;
                        go_resp   = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (mismatch) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    go_resp   = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Writes commit on the edge entering RESP; a reset on that edge suppresses them.
    assign mem_we = (go_resp && !RST && cur_wen && !fault) ? cur_be : 4'b0000;

    sram_1rw_be #(.DEPTH(DEPTH)) u_sram (
        .CLK   (CLK),
        .we    (mem_we),
        .idx   (index),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    // Request latch (p0), held for the whole transaction
    always_ff @(posedge CLK) begin
        if ((state == IDLE) && req) begin
            addr_p0    <= bus_if.addr;
            wdata_p0   <= bus_if.wdata;
            byte_en_p0 <= bus_if.byte_en;
            ren_p0     <= bus_if.ren;
            wen_p0     <= bus_if.wen;
        end
    end

    // Registered response (p1), valid only while in RESP
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            busy_p1  <= 1'b1;
            error_p1 <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            busy_p1  <= !go_resp;
            error_p1 <= go_resp && fault;
            rdata_p1 <= (go_resp && cur_ren && !fault) ? mem_rdata : '0;
        end
    end

    assign bus_if.rdata = rdata_p1;
    assign bus_if.busy  = busy_p1;
    assign bus_if.error = error_p1;

endmodule

// File: doc/generic_bus_sram_responder.md
Name: generic_bus_sram_responder

Overview:
- Device-side (responder) end of generic_bus_if: a word-organised, byte-maskable scratchpad data memory.
- It answers the requests a pipeline memory stage issues (ren/wen/addr/wdata/byte_en) with busy/rdata/error.
- Latency is configurable, so the hazard unit's d_mem_busy and fault_l/fault_s paths can be exercised without a cache or bus bridge.
- Sits directly behind the data port (dgen_bus_if) in core-only and unit-test configurations.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- DEPTH, 1024, number of 32-bit words; power of two, >= 2.
- LAT, 2, request-to-response cycles; legal range 1..15.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  synchronous, active-high reset.
- bus_if.addr  input  32  byte address (generic_bus_if.generic_bus modport).
- bus_if.ren  input  1  read request.
- bus_if.wen  input  1  write request.
- bus_if.wdata  input  32  write data.
- bus_if.byte_en  input  4  byte lanes; bit i covers data[8i+7:8i].
- bus_if.rdata  output  32  read data; valid only in the completion cycle.
- bus_if.busy  output  1  low for exactly one cycle per completed request.
- bus_if.error  output  1  access fault, valid only in the completion cycle.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST.
- Reset: state=IDLE, cnt=0, busy=1, error=0, rdata=0. Memory array is not cleared.
- Reset mid-operation: aborts the request with no write and no completion.
- Decode: in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*DEPTH); index = (addr - BASE_ADDR)[log2(DEPTH)+1:2]; addr[1:0] is ignored.
- Request latch:
  - Outputs are registered.
  - Request = ren | wen, sampled in IDLE.
  - The latched copy (addr, wdata, byte_en, ren, wen) is held for the whole transaction.
- FSM states:
  - IDLE: busy=1. On request, latch it; cnt=LAT-1. If cnt==0 go to RESP, else go to WAIT.
  - WAIT: busy=1, cnt decrements each cycle. If the live request no longer matches the latch (ren, wen or addr changed, or both strobes low), go to IDLE with no side effect; this supports hazard-unit suppression. When cnt reaches 0 go to RESP.
  - RESP: one cycle. busy=0.
    - In-range read: rdata = mem[index].
    - In-range write: on this edge mem[index] byte lane i <= wdata lane i where byte_en[i]=1; rdata=0.
    - Error case: error=1, rdata=0, no write, where error = !in_range, or ren&&wen, or wen with byte_en==0.
    - Next state is always IDLE.
- Latency: request first visible in IDLE at cycle t -> busy=0 at cycle t+LAT.
- Back-to-back: an initiator that holds the strobes through RESP starts a new transaction in the next IDLE. The minimum request period is LAT+1 cycles.
- Read-after-write to the same word in consecutive transactions returns the merged data.
- Reads return the full word regardless of byte_en; lane selection and extension are the initiator's job.
- Wrap-around: addr = BASE_ADDR + 4*DEPTH - 1 is in range (last word). BASE_ADDR + 4*DEPTH faults. Address arithmetic is done in 33 bits, so BASE_ADDR near 2^32 does not wrap.
- Outside RESP: error=0 and rdata=0.

Decomposition:
- rv32i_types_pkg: word_t, reused.
- Local to the module: state enum {IDLE, WAIT, RESP}. Add a generic_bus_resp_pkg only if a second responder appears.
- One sub-module, sram_1rw_be:
  - Single-port DEPTH x 32 array with 4-bit write-lane enable and synchronous write.
  - Combinational read, registered at the responder output.
  - Lets FPGA targets swap in a BRAM macro.
- The FSM, counter, latch and decode live in the top module.

Test Plan:
- Reset then idle, LAT=2: RST high 3 cycles -> busy=1, error=0, rdata=0 during and after, state IDLE.
- Full write then read, LAT=2:
  - Write addr=0x10, wdata=0xDEADBEEF, byte_en=4'hF: busy low exactly at t+2.
  - Read 0x10: busy low at t+2 with rdata=0xDEADBEEF, error=0.
- Byte merge: over the above word, write byte_en=4'b0100, wdata=0x00AA0000 -> subsequent read returns 0xDEAABEEF.
- Fault:
  - Read addr=BASE_ADDR+4*DEPTH (0x1000): error=1, busy=0 at t+2, rdata=0.
  - ren&wen together: error=1, memory unchanged.
- Abort: start a write to 0x20 (LAT=4), drop wen at t+2 -> returns to IDLE, busy never low, and a later read of 0x20 returns the old value.
- Corners:
  - LAT=1: busy low at t+1.
  - Back-to-back reads held asserted complete every 2 cycles.
  - RST asserted in WAIT cancels the pending write (memory unchanged, busy=1).
